// File: rtl/dec_param_strobe_pkg.sv
// Shared types for the binary/one-hot decoder family.
// The state encoding is fixed (IDLE=0, HOLD=1) so the matching encoder and any
// bound checkers agree on what the debug state output means.
package dec_param_strobe_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/dec_bin2oh.sv
// Combinational binary-to-one-hot decode with range flag.
// An index at or beyond ONEHOT_WIDTH decodes to all zeros and clears o_in_range.
// This can only happen when ONEHOT_WIDTH is not a power of two.
module dec_bin2oh #(
  parameter int ONEHOT_WIDTH = 16,
  parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
  input  logic [BIN_WIDTH-1:0]    i_bin,
  output logic [ONEHOT_WIDTH-1:0] o_one_hot,
  output logic                    o_in_range
);

  localparam logic [31:0] WIDTH_U = ONEHOT_WIDTH;

  // One comparator per output line; at most one line can match.
  for (genvar i = 0; i < ONEHOT_WIDTH; i++) begin : g_line
    assign o_one_hot[i] = (i_bin == BIN_WIDTH'(i));
  end

  // Zero-extend the index so the range test never truncates ONEHOT_WIDTH.
  assign o_in_range = (32'(i_bin) < WIDTH_U);

endmodule

// File: rtl/dec_param_strobe.sv
// Binary-to-one-hot strobe generator.
// An accepted index drives its one-hot line for exactly HOLD_CYCLES clocks.
// An out-of-range index is consumed without a strobe and raises a sticky error.
//
// Handshake: a transfer happens on a rising edge where i_valid && o_ready.
// o_ready comes only from registered state: it is high in IDLE, and high in
// the last HOLD cycle (cnt==0). It never looks at i_valid, so upstream may
// assert or drop i_valid freely without forming a combinational loop.
// Upstream need not keep i_valid high while o_ready is low.
// While o_ready is low, i_valid and i_bin are ignored.
module dec_param_strobe
  import dec_param_strobe_pkg::*;
#(
  parameter int ONEHOT_WIDTH = 16,
  parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH),
  parameter int HOLD_CYCLES  = 4,
  parameter int CNT_WIDTH    = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [BIN_WIDTH-1:0]    i_bin,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [ONEHOT_WIDTH-1:0] o_one_hot,
  output logic                    o_active,
  output logic                    o_err,
  input  logic                    i_clr_err,
  output logic                    o_state
);

  // The counter holds the remaining extra cycles after the first strobe cycle.
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [ONEHOT_WIDTH-1:0] one_hot_q, one_hot_d;
  logic                    active_q, active_d;
  logic                    err_q, err_d;

  logic [ONEHOT_WIDTH-1:0] dec_one_hot;
  logic                    dec_in_range;
  logic                    ready;
  logic                    accept;

  dec_bin2oh #(
    .ONEHOT_WIDTH (ONEHOT_WIDTH),
    .BIN_WIDTH    (BIN_WIDTH)
  ) u_bin2oh (
    .i_bin      (i_bin),
    .o_one_hot  (dec_one_hot),
    .o_in_range (dec_in_range)
  );

  // Ready from state only: idle, or the final cycle of a hold.
  always_comb begin
    ready = (state_q == ST_IDLE) || (cnt_q == '0);
  end

  assign accept = i_valid && ready;

  // Next-state logic. The load path is shared by IDLE and the final HOLD cycle.
  // This sharing gives back-to-back strobes with no idle gap between them.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    one_hot_d = one_hot_q;
    active_d  = active_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_in_range) begin
            one_hot_d = dec_one_hot;
            active_d  = 1'b1;
            cnt_d     = CNT_LOAD;
            state_d   = ST_HOLD;
          end else begin
            one_hot_d = '0;
            active_d  = 1'b0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else if (accept && dec_in_range) begin
          one_hot_d = dec_one_hot;
          active_d  = 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = ST_HOLD;
        end else begin
          // Hold expired, and either nothing new arrived or a bad index was consumed.
          one_hot_d = '0;
          active_d  = 1'b0;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        one_hot_d = '0;
        active_d  = 1'b0;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Sticky error: a bad index that arrives in the same cycle as a clear takes priority.
  always_comb begin
    err_d = err_q;
    if (accept && !dec_in_range) begin
      err_d = 1'b1;
    end else if (i_clr_err) begin
      err_d = 1'b0;
    end
  end

  // State and output registers. Asserting reset clears the outputs at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      one_hot_q <= '0;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      one_hot_q <= one_hot_d;
      active_q  <= active_d;
      err_q     <= err_d;
    end
  end

  assign o_ready   = ready;
  assign o_one_hot = one_hot_q;
  assign o_active  = active_q;
  assign o_err     = err_q;
  assign o_state   = state_q;

endmodule
